// File: rtl/nios_nios2_gen2_cpu_debug_ocimem_arbiter.sv
// OCI debug RAM arbiter: shares the single-port RAM between
// latched JTAG commands and the CPU debug-monitor port.
module nios_nios2_gen2_cpu_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {
    IDLE,
    JACC,
    JCAP,
    CACC,
    CCAP,
    CDONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] jaddr;
  logic [DATA_W-1:0] jwdata;
  logic              jpend;
  logic              jread;
  logic              last_grant;
  logic              cpu_req;
  logic              jbusy;
  logic              acc_a;
  logic              acc_b;
  logic              drop;
  logic              tie;
  logic              grant_j;
  logic              grant_c;
  logic              unused_jdo;

  assign unused_jdo = jdo[36];

  assign cpu_req = cpu_read | cpu_write;
  assign jbusy   = (state == JACC) || (state == JCAP);

  // A strobe is only taken when no JTAG command is queued or in flight;
  // when both strobes collide the data strobe loses.
  assign acc_a = take_action_ocimem_a & ~jpend & ~jbusy;
  assign acc_b = take_action_ocimem_b & ~take_action_ocimem_a
               & ~jpend & ~jbusy;
  assign drop  = (take_action_ocimem_a & ~acc_a)
               | (take_action_ocimem_b & ~acc_b);

  // last_grant=1 means JTAG won the previous tie.
  assign tie     = jpend & cpu_req;
  assign grant_j = jpend & (~cpu_req | ~last_grant);
  assign grant_c = cpu_req & ~grant_j;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      jaddr           <= '0;
      jwdata          <= '0;
      jpend           <= 1'b0;
      jread           <= 1'b0;
      last_grant      <= 1'b0;
      cpu_readdata    <= '0;
      cpu_waitrequest <= 1'b1;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      MonDReg         <= '0;
      monitor_ready   <= 1'b1;
      monitor_error   <= 1'b0;
    end else begin
      if (take_action_ocimem_a & jdo[37]) begin
        monitor_error <= 1'b0;
      end else if (drop) begin
        monitor_error <= 1'b1;
      end

      if (acc_a) begin
        jaddr <= jdo[ADDR_W-1:0];
        if (jdo[35]) begin
          jpend         <= 1'b1;
          jread         <= 1'b1;
          monitor_ready <= 1'b0;
        end
      end

      if (acc_b) begin
        jwdata        <= jdo[34:3];
        jpend         <= 1'b1;
        jread         <= 1'b0;
        monitor_ready <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (grant_j) begin
            state     <= JACC;
            jpend     <= 1'b0;
            mem_addr  <= jaddr;
            mem_wdata <= jwdata;
            mem_we    <= ~jread;
            mem_re    <= jread;
            if (tie) last_grant <= 1'b1;
          end else if (grant_c) begin
            state     <= CACC;
            mem_addr  <= cpu_address;
            mem_wdata <= cpu_writedata;
            mem_we    <= cpu_write;
            mem_re    <= ~cpu_write;
            if (cpu_write) cpu_waitrequest <= 1'b0;
            if (tie) last_grant <= 1'b0;
          end
        end
        JACC: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (jread) begin
            state <= JCAP;
          end else begin
            state         <= IDLE;
            monitor_ready <= 1'b1;
            jaddr         <= jaddr + 1'b1;
          end
        end
        JCAP: begin
          state         <= IDLE;
          MonDReg       <= mem_rdata;
          monitor_ready <= 1'b1;
          jaddr         <= jaddr + 1'b1;
        end
        CACC: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (mem_we) begin
            state           <= IDLE;
            cpu_waitrequest <= 1'b1;
          end else begin
            state <= CCAP;
          end
        end
        CCAP: begin
          state           <= CDONE;
          cpu_readdata    <= mem_rdata;
          cpu_waitrequest <= 1'b0;
        end
        CDONE: begin
          state           <= IDLE;
          cpu_waitrequest <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_nios2_gen2_cpu_debug_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural
// one-cycle-latency RAM model.
module tb_nios_nios2_gen2_cpu_debug_ocimem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a;
  logic        take_b;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [31:0] mon_dreg;
  logic        monitor_ready;
  logic        monitor_error;

  logic [31:0] ram [256];
  int          we_cnt;
  int          re_cnt;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  int checks;
  int errors;
  int base;

  nios_nios2_gen2_cpu_debug_ocimem_arbiter dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .jdo                  (jdo),
    .take_action_ocimem_a (take_a),
    .take_action_ocimem_b (take_b),
    .cpu_address          (cpu_address),
    .cpu_read             (cpu_read),
    .cpu_write            (cpu_write),
    .cpu_writedata        (cpu_writedata),
    .cpu_readdata         (cpu_readdata),
    .cpu_waitrequest      (cpu_waitrequest),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_we               (mem_we),
    .mem_re               (mem_re),
    .mem_rdata            (mem_rdata),
    .MonDReg              (mon_dreg),
    .monitor_ready        (monitor_ready),
    .monitor_error        (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) begin
      mem_rdata <= ram[mem_addr];
      re_cnt <= re_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] ja(input logic [7:0] a,
                                     input logic rd,
                                     input logic clr);
    logic [37:0] v;
    v = '0;
    v[7:0] = a;
    v[35] = rd;
    v[37] = clr;
    return v;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    we_cnt = 0;
    re_cnt = 0;
    pl_en = 0;
    pl_addr = '0;
    pl_data = '0;
    mem_rdata = '0;
    reset_n = 0;
    jdo = '0;
    take_a = 0;
    take_b = 0;
    cpu_address = '0;
    cpu_read = 0;
    cpu_write = 0;
    cpu_writedata = '0;

    repeat (2) step();
    chk("rst_ready", monitor_ready, 1);
    chk("rst_error", monitor_error, 0);
    chk("rst_wait", cpu_waitrequest, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mondreg", mon_dreg, 0);
    chk("rst_rdata", cpu_readdata, 0);
    reset_n = 1;
    step();

    // JTAG write 0xDEADBEEF to 0x10 then read it back
    take_a = 1; jdo = ja(8'h10, 0, 0);
    step();
    take_a = 0;
    chk("addr_only_ready", monitor_ready, 1);
    take_b = 1; jdo = jb(32'hDEADBEEF);
    step();
    take_b = 0;
    chk("jw_ready_low", monitor_ready, 0);
    step();
    chk("jw_we", mem_we, 1);
    chk("jw_addr", mem_addr, 8'h10);
    chk("jw_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("jw_done_ready", monitor_ready, 1);
    chk("jw_done_we", mem_we, 0);
    take_a = 1; jdo = ja(8'h10, 1, 0);
    step();
    take_a = 0;
    chk("jr_ready_low", monitor_ready, 0);
    step();
    chk("jr_re", mem_re, 1);
    chk("jr_addr", mem_addr, 8'h10);
    step();
    chk("jr_cap_ready", monitor_ready, 0);
    step();
    chk("jr_mondreg", mon_dreg, 32'hDEADBEEF);
    chk("jr_ready", monitor_ready, 1);
    // jaddr should now be 0x11
    take_b = 1; jdo = jb(32'h12345678);
    step();
    take_b = 0;
    step();
    chk("inc_we", mem_we, 1);
    chk("inc_addr", mem_addr, 8'h11);
    step();

    // Dropped command while jpend=1
    base = re_cnt;
    take_a = 1; jdo = ja(8'h30, 1, 0);
    step();
    jdo = ja(8'h40, 1, 0);
    step();
    take_a = 0;
    chk("drop_error", monitor_error, 1);
    chk("drop_re", mem_re, 1);
    chk("drop_addr", mem_addr, 8'h30);
    step();
    chk("drop_re_off", mem_re, 0);
    step();
    chk("drop_ready", monitor_ready, 1);
    step();
    chk("drop_one_access", re_cnt - base, 1);
    chk("drop_error_sticky", monitor_error, 1);
    take_a = 1; jdo = ja(8'h50, 0, 1);
    step();
    take_a = 0;
    chk("clear_error", monitor_error, 0);

    // Both strobes together: b dropped; clear wins over set
    take_a = 1; take_b = 1; jdo = ja(8'h60, 0, 0);
    step();
    chk("both_error", monitor_error, 1);
    jdo = ja(8'h60, 0, 1);
    step();
    take_a = 0; take_b = 0;
    chk("clear_priority", monitor_error, 0);
    step();
    chk("both_no_we", mem_we, 0);
    chk("both_ready", monitor_ready, 1);

    // Address wrap
    take_a = 1; jdo = ja(8'hFF, 0, 0);
    step();
    take_a = 0; take_b = 1; jdo = jb(32'hCAFEF00D);
    step();
    take_b = 0;
    step();
    chk("wrap_we", mem_we, 1);
    chk("wrap_addr_ff", mem_addr, 8'hFF);
    step();
    take_b = 1; jdo = jb(32'h11111111);
    step();
    take_b = 0;
    step();
    chk("wrap_addr_00", mem_addr, 8'h00);
    chk("wrap_we2", mem_we, 1);
    step();

    // Async reset during JACC of a write
    take_a = 1; jdo = ja(8'h70, 0, 0);
    step();
    take_a = 0; take_b = 1; jdo = jb(32'hAAAA5555);
    step();
    take_b = 0;
    step();
    chk("ar_we_before", mem_we, 1);
    base = we_cnt;
    #2;
    reset_n = 0;
    #1;
    chk("ar_we", mem_we, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_ready", monitor_ready, 1);
    chk("ar_wait", cpu_waitrequest, 1);
    chk("ar_mondreg", mon_dreg, 0);
    step();
    preload(8'h20, 32'h0BADF00D);
    preload(8'h21, 32'h600DCAFE);
    preload(8'h22, 32'h13579BDF);
    reset_n = 1;
    step();
    step();
    chk("ar_post_we", mem_we, 0);
    chk("ar_post_re", mem_re, 0);
    chk("ar_no_write", we_cnt - base, 0);

    // Tie after reset: JTAG first
    take_a = 1; jdo = ja(8'h21, 1, 0);
    step();
    take_a = 0; cpu_read = 1; cpu_address = 8'h20;
    step();
    chk("tie1_jre", mem_re, 1);
    chk("tie1_jaddr", mem_addr, 8'h21);
    chk("tie1_wait", cpu_waitrequest, 1);
    step();
    step();
    chk("tie1_mondreg", mon_dreg, 32'h600DCAFE);
    chk("tie1_wait2", cpu_waitrequest, 1);
    step();
    chk("tie1_cre", mem_re, 1);
    chk("tie1_caddr", mem_addr, 8'h20);
    step();
    chk("tie1_wait3", cpu_waitrequest, 1);
    step();
    chk("tie1_cdone", cpu_waitrequest, 0);
    chk("tie1_rdata", cpu_readdata, 32'h0BADF00D);
    cpu_read = 0;
    step();
    chk("tie1_wait_back", cpu_waitrequest, 1);

    // Second tie: CPU first
    take_a = 1; jdo = ja(8'h22, 1, 0);
    step();
    take_a = 0; cpu_read = 1; cpu_address = 8'h21;
    step();
    chk("tie2_cre", mem_re, 1);
    chk("tie2_caddr", mem_addr, 8'h21);
    step();
    step();
    chk("tie2_cdone", cpu_waitrequest, 0);
    chk("tie2_rdata", cpu_readdata, 32'h600DCAFE);
    chk("tie2_jwaiting", monitor_ready, 0);
    cpu_read = 0;
    step();
    step();
    chk("tie2_jre", mem_re, 1);
    chk("tie2_jaddr", mem_addr, 8'h22);
    step();
    step();
    chk("tie2_mondreg", mon_dreg, 32'h13579BDF);
    chk("tie2_ready", monitor_ready, 1);

    // CPU back-to-back writes with request held
    base = we_cnt;
    cpu_write = 1; cpu_address = 8'h01; cpu_writedata = 32'hA1;
    step();
    chk("b2b1_wait", cpu_waitrequest, 0);
    chk("b2b1_we", mem_we, 1);
    chk("b2b1_addr", mem_addr, 8'h01);
    chk("b2b1_wdata", mem_wdata, 32'hA1);
    cpu_address = 8'h02; cpu_writedata = 32'hA2;
    step();
    chk("b2b_idle_wait", cpu_waitrequest, 1);
    chk("b2b_idle_we", mem_we, 0);
    step();
    chk("b2b2_wait", cpu_waitrequest, 0);
    chk("b2b2_addr", mem_addr, 8'h02);
    chk("b2b2_we", mem_we, 1);
    cpu_write = 0;
    step();
    chk("b2b_end_we", mem_we, 0);
    chk("b2b_we_count", we_cnt - base, 2);
    cpu_read = 1; cpu_address = 8'h02;
    step();
    chk("crd_re", mem_re, 1);
    step();
    chk("crd_wait", cpu_waitrequest, 1);
    step();
    chk("crd_done", cpu_waitrequest, 0);
    chk("crd_data", cpu_readdata, 32'hA2);
    cpu_read = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_nios2_gen2_cpu_debug_ocimem_arbiter.md
# nios_nios2_gen2_cpu_debug_ocimem_arbiter

Sysclk-domain controller that shares the single-port on-chip debug memory (256 x 32 OCI RAM) between two requesters. One is the JTAG debug path, driven by the `take_action_ocimem_*` strobes and `jdo` from the debug slave. The other is the CPU's debug-monitor data port. It latches one-cycle JTAG commands, arbitrates round-robin against CPU accesses, sequences the RAM's one-cycle read latency, and returns read data through `MonDReg` with `monitor_ready`/`monitor_error` status.

## Interface
Parameters:
- `ADDR_W`, 8: OCI RAM word-address width.
- `DATA_W`, 32: data width; `jdo` field positions below assume 32.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `jdo`  in  38  JTAG data-out word.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address, optional read.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write data.
- `cpu_address`  in  ADDR_W  CPU word address.
- `cpu_read`  in  1  CPU read request, held until accepted.
- `cpu_write`  in  1  CPU write request, held until accepted.
- `cpu_writedata`  in  DATA_W  CPU write data.
- `cpu_readdata`  out  DATA_W  CPU read data; valid when `cpu_waitrequest`=0 on a read.
- `cpu_waitrequest`  out  1  registered; low for exactly one cycle per completed CPU access.
- `mem_addr`  out  ADDR_W  RAM address, registered.
- `mem_wdata`  out  DATA_W  RAM write data, registered.
- `mem_we`  out  1  RAM write enable, registered.
- `mem_re`  out  1  RAM read enable, registered; `mem_rdata` valid the following cycle.
- `mem_rdata`  in  DATA_W  RAM read data.
- `MonDReg`  out  DATA_W  last JTAG read result.
- `monitor_ready`  out  1  JTAG command complete.
- `monitor_error`  out  1  sticky: JTAG command dropped.

## Operation
- **`ocimem_a`**
  - `jaddr` <= `jdo[ADDR_W-1:0]`.
  - If `jdo[35]`=1, queue a JTAG read.
  - If `jdo[37]`=1, clear `monitor_error`. The clear has priority over a set in the same cycle.
- **`ocimem_b`**
  - `jwdata` <= `jdo[34:3]`.
  - Queue a JTAG write at `jaddr`.
- **Auto-increment:** each completed JTAG access increments `jaddr` modulo 2^ADDR_W (0xFF -> 0x00).
- **Command acceptance:** an accepted strobe sets `jpend` and clears `monitor_ready`.
  - A strobe arriving while `jpend`=1 or a JTAG access is in flight is dropped and sets `monitor_error`.
  - If both strobes arrive in the same cycle, `ocimem_b` is dropped and `monitor_error` is set.
- **FSM states:** IDLE, JACC, JCAP, CACC, CCAP, CDONE.
  - IDLE: on pending requests, grant and go to JACC (JTAG) or CACC (CPU).
  - JACC: drive `mem_re`/`mem_we` for one cycle. Read -> JCAP; write -> IDLE with `monitor_ready` set.
  - JCAP: `MonDReg` <= `mem_rdata`, set `monitor_ready`, -> IDLE.
  - CACC: drive the RAM for one cycle. Write -> IDLE with `cpu_waitrequest`=0 in this cycle. Read -> CCAP.
  - CCAP: `cpu_readdata` <= `mem_rdata`, -> CDONE.
  - CDONE: `cpu_waitrequest`=0, -> IDLE.
- **Arbitration:** round-robin on `last_grant` (reset = CPU), so JTAG wins the first tie. When only one requester is pending, it is granted regardless of `last_grant`.
- **CPU request decoding:** a CPU request is `cpu_read|cpu_write`, sampled only in IDLE. If both are high, the access is treated as a write.
- **Reset values:** `MonDReg`=0, `cpu_readdata`=0, `mem_*`=0, `monitor_ready`=1, `monitor_error`=0, `cpu_waitrequest`=1, `jaddr`=0, `jpend`=0, state IDLE.
- **Reset mid-access:** asserting reset during an access aborts it. No `mem_we` is produced after reset asserts, and the pending command is discarded.

## Timing
- **JTAG strobe at edge N:**
  - `jpend`=1 and `monitor_ready`=0 from N+1.
  - With no contention: state JACC and `mem_re`/`mem_we` high during N+2.
  - Write: `monitor_ready`=1 from N+3.
  - Read: `MonDReg` valid and `monitor_ready`=1 from N+4.
- **CPU request first sampled in IDLE at cycle M:**
  - Write: RAM write in M+1, `cpu_waitrequest`=0 in M+1.
  - Read: `mem_re` in M+1, `cpu_readdata` valid and `cpu_waitrequest`=0 in M+3.
  - A request still held high in the completion cycle is not re-granted. The next request is sampled at the following IDLE cycle.
- **Losing requester:** waits at most one full access of the other side (read: 3 cycles, write: 1 cycle).

## Test plan
- **JTAG write then read:** `ocimem_a` (`jdo[7:0]`=0x10, `jdo[35]`=0), then `ocimem_b` with data 0xDEADBEEF, then `ocimem_a` (0x10, read). Expect `mem_we` at address 0x10, `MonDReg`=0xDEADBEEF and `monitor_ready`=1 at N+4 of the read strobe, and `jaddr`=0x11 afterwards.
- **Simultaneous requests:** JTAG read and CPU read of 0x20 pending together in IDLE after reset. Expect JTAG granted first and the CPU sees `cpu_waitrequest`=0 with correct data 6 cycles after its request. Repeat the tie and expect the CPU granted first.
- **Dropped command:** second `ocimem_a` arrives at N+1 while `jpend`=1. Expect `monitor_error`=1 and only one RAM access. A later `ocimem_a` with `jdo[37]`=1 clears the error.
- **Address wrap:** `jaddr`=0xFF, JTAG write. Expect `mem_addr`=0xFF, then `jaddr`=0x00.
- **CPU back-to-back:** writes to 0x01 and 0x02 with the request held. Expect each to complete in 1 cycle with one IDLE cycle between, and no duplicate `mem_we`.
- **Async reset:** assert `reset_n`=0 during JACC of a write. Expect `mem_we`=0 immediately, all outputs at their reset values, and state IDLE with `jpend`=0 after release.
